spi_cmd_seq: RTL and testbench
==============================

# spi_cmd_seq

Command sequencer that sits directly upstream of the scope's SPI master. It buffers 16-bit SPI commands from the host/command-processing logic in a small FIFO, issues them to the SPI master one at a time with a `wrt` pulse, and waits for `done` before issuing the next. It enforces a minimum inter-transaction gap, detects a hung transaction with a timeout, and, optionally, captures each transaction's read-back word for the host.

## Interface
Parameters:
- DEPTH, 4, command FIFO entries; power of 2, ≥2.
- GAP, 8, minimum idle clk cycles between `done` and the next `wrt`; range 0..255.
- TIMEOUT, 1023, clk cycles allowed in WAIT_DONE before abort; range 1..65535.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_in  in  16  command word from the host.
- cmd_vld  in  1  `cmd_in` is valid.
- cmd_rdy  out  1  FIFO can accept a word (not full).
- wrt  out  1  one-cycle start pulse to the SPI master.
- cmd  out  16  command word to the SPI master; holds the last issued value.
- done  in  1  one-cycle completion pulse from the SPI master.
- data  in  16  read-back word from the SPI master; valid when `done`=1.
- rsp  out  16  captured read-back word.
- rsp_vld  out  1  `rsp` holds an unconsumed word.
- rsp_ack  in  1  host consumes `rsp`.
- busy  out  1  FIFO is non-empty or the FSM is not in IDLE.
- err  out  1  sticky flag: a timeout has occurred.

## Operation
- Push: a word is written on any edge with `cmd_vld`=1 and `cmd_rdy`=1.
  - `cmd_rdy` is `!full`. A push attempted while full is dropped.
  - A push and a pop on the same edge are both performed; the count is unchanged.
- FIFO: circular buffer with wrapping read and write pointers plus an occupancy count of `$clog2(DEPTH)+1` bits.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
  - IDLE → ISSUE when the FIFO is non-empty and `rsp_vld`=0. In the same edge, the head word is registered to `cmd` and popped.
  - ISSUE: `wrt`=1 for this cycle only. Next state is WAIT_DONE and the timeout counter is cleared.
  - WAIT_DONE, when `done`=1: capture `data` into `rsp` and set `rsp_vld`. Then go to GAP if GAP>0, else to IDLE.
  - WAIT_DONE, when the counter reaches TIMEOUT-1 without `done`: set `err`, capture nothing, and go to GAP (or to IDLE if GAP=0).
  - GAP: 8-bit down-counter loaded with GAP-1 on entry. Go to IDLE when it reaches 0.
- `done` seen outside WAIT_DONE is ignored.
- `rsp_vld` is cleared on an edge where `rsp_vld`=1 and `rsp_ack`=1. Because issue is blocked while `rsp_vld`=1, a capture and an ack can never fall on the same edge.
- `err` is cleared only by reset.
- `busy` = (state≠IDLE) || (count≠0).

## Timing
- Reset values: `cmd_rdy`=1, `wrt`=0, `cmd`=16'h0000, `rsp`=16'h0000, `rsp_vld`=0, `busy`=0, `err`=0. FSM is in IDLE and the FIFO is empty.
- `wrt`, `cmd`, `rsp`, `rsp_vld` and `err` are registered outputs.
- Push into an empty FIFO with the FSM in IDLE: `wrt` rises on the first edge after the push edge, and is high for exactly 1 cycle.
- `done` to `rsp_vld`: `rsp_vld` rises on the edge that samples `done`=1.
- Back-to-back commands: the next `wrt` is GAP+1 cycles after the `done` edge (1 cycle when GAP=0), provided `rsp_vld` has been cleared.
- Timeout: `err` rises TIMEOUT cycles after the ISSUE cycle.
- Reset mid-transaction: FIFO contents, the response and any in-flight command are discarded. `wrt` never glitches high during reset.

## Configuration
- `SPI_SEQ_READBACK_EN` defined: response capture, `rsp_vld` and `rsp_ack` behave as described above, and issue stalls while `rsp_vld`=1.
- `SPI_SEQ_READBACK_EN` undefined:
  - `rsp` is tied to 16'h0000 and `rsp_vld` to 0.
  - `rsp_ack` is ignored.
  - Issue never stalls on a response; `data` is discarded.

## Test plan
- Single command: push 16'hA5C3 and respond with `done` 40 cycles later carrying `data`=16'h1234. Required: `wrt` for 1 cycle with `cmd`=16'hA5C3 one cycle after the push; `rsp`=16'h1234 and `rsp_vld`=1 on the `done` edge; `busy` drops GAP cycles later.
- Fill and wrap: push 6 words while the sequencer is busy, with DEPTH=4. Required: `cmd_rdy`=0 once 4 are held and the extra push is dropped; the accepted words are issued in order across pointer wrap-around.
- Response stall (readback on): leave `rsp_ack`=0 after the first `done`. Required: no second `wrt` until `rsp_ack`; the next `wrt` follows one cycle after `rsp_vld` clears.
- Timeout: never assert `done`, with TIMEOUT=100. Required: `err`=1 exactly 100 cycles after ISSUE, `rsp_vld` stays 0, and the next queued command still issues after the gap.
- Simultaneous push/pop at full: hold the FIFO full and push on the same edge as an ISSUE pop. Required: the push is dropped (`cmd_rdy`=0) and the count goes from 4 to 3.
- Reset mid-WAIT_DONE: assert `rst_n`=0 with 3 words queued. Required: all outputs return to reset values immediately, and no `wrt` follows reset release.

Source files
------------

// File: rtl/spi_cmd_seq.sv
// spi_cmd_seq: buffers 16-bit SPI commands in a FIFO and issues them one at a time (wrt/done handshake).
// Optional feature macro SPI_SEQ_READBACK_EN: capture read-back words into rsp/rsp_vld and stall issue until acked.
module spi_cmd_seq #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd_in,
    input  logic        cmd_vld,
    output logic        cmd_rdy,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] data,
    output logic [15:0] rsp,
    output logic        rsp_vld,
    input  logic        rsp_ack,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    logic [15:0]   tmo_cnt_r;
    logic [7:0]    gap_cnt_r;
    logic          wrt_r;
    logic [15:0]   cmd_r;
    logic          err_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          stall_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = cmd_vld && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s && !stall_s;

    // FIFO storage; no reset needed because the pointers and count decide what is visible.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue sequencer: pop and register the head word, pulse wrt, wait for done or timeout, then hold off for the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            wrt_r     <= 1'b0;
            cmd_r     <= 16'h0000;
            tmo_cnt_r <= 16'h0000;
            gap_cnt_r <= 8'h00;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        cmd_r   <= mem_r[rd_ptr_r];
                        wrt_r   <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wrt_r     <= 1'b0;
                    tmo_cnt_r <= 16'h0000;
                    state_r   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (done || (tmo_cnt_r == 16'(TIMEOUT - 1))) begin
                        if (!done) begin
                            err_r <= 1'b1;
                        end
                        if (GAP > 0) begin
                            gap_cnt_r <= 8'(GAP - 1);
                            state_r   <= ST_GAP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 8'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    wrt_r   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_SEQ_READBACK_EN
    logic [15:0] rsp_r;
    logic        rsp_vld_r;
    logic        capture_s;

    assign capture_s = (state_r == ST_WAIT_DONE) && done;

    // Response holding register; capture and ack cannot coincide because issue stalls while rsp_vld is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_r     <= 16'h0000;
            rsp_vld_r <= 1'b0;
        end else begin
            if (capture_s) begin
                rsp_r     <= data;
                rsp_vld_r <= 1'b1;
            end else if (rsp_vld_r && rsp_ack) begin
                rsp_vld_r <= 1'b0;
            end
        end
    end

    assign stall_s = rsp_vld_r;
    assign rsp     = rsp_r;
    assign rsp_vld = rsp_vld_r;
`else
    logic unused_s;

    assign unused_s = ^{data, rsp_ack};
    assign stall_s  = 1'b0;
    assign rsp      = 16'h0000;
    assign rsp_vld  = 1'b0;
`endif

    assign cmd_rdy = !full_s;
    assign wrt     = wrt_r;
    assign cmd     = cmd_r;
    assign err     = err_r;
    assign busy    = (state_r != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Randomized scoreboard bench for spi_cmd_seq: a timestamp-based reference model predicts each issue,
// the response, err, busy and cmd_rdy; a negedge monitor compares the DUT against it.
module tb_spi_cmd_seq;
    localparam int DEPTH   = 4;
    localparam int GAP     = 8;
    localparam int TIMEOUT = 100;
`ifdef SPI_SEQ_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_in;
    logic        cmd_vld;
    logic        cmd_rdy;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] data;
    logic [15:0] rsp;
    logic        rsp_vld;
    logic        rsp_ack;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    spi_cmd_seq #(.DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .wrt(wrt), .cmd(cmd), .done(done), .data(data), .rsp(rsp), .rsp_vld(rsp_vld),
        .rsp_ack(rsp_ack), .busy(busy), .err(err)
    );

    typedef struct {
        int          cyc;
        logic [15:0] word;
    } iss_t;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    iss_t        exp_q[$];
    logic [15:0] mq[$];
    bit          m_active;
    int          m_wait_from, m_tmo_at, m_free_at, done_at;
    bit          m_err, m_rsp_vld, m_busy, m_rdy;
    logic [15:0] m_rsp, m_cmd;
    bit          chk_en, spur_en, force_tmo, fix_data;
    int          next_lat;
    iss_t        mon_e;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_active  = 1'b0;
        m_free_at = 0;
        done_at   = -1;
        m_err     = 1'b0;
        m_rsp_vld = 1'b0;
        m_rsp     = 16'h0000;
        m_cmd     = 16'h0000;
        m_busy    = 1'b0;
        m_rdy     = 1'b1;
    endtask

    // Reference behaviour for edge t, using the inputs present at that edge.
    task automatic model_step(int t);
        int n;
        bit do_push, do_pop;
        n       = mq.size();
        do_push = cmd_vld && (n < DEPTH);
        do_pop  = !m_active && (t >= m_free_at) && (n > 0) && !(RB && m_rsp_vld);
        if (RB && m_rsp_vld && rsp_ack) m_rsp_vld = 1'b0;
        if (m_active && t >= m_wait_from) begin
            if (done) begin
                if (RB) begin
                    m_rsp_vld = 1'b1;
                    m_rsp     = data;
                end
                m_active  = 1'b0;
                m_free_at = t + GAP + 1;
            end else if (t == m_tmo_at) begin
                m_err     = 1'b1;
                m_active  = 1'b0;
                m_free_at = t + GAP + 1;
            end
        end
        if (do_pop) begin
            m_cmd = mq.pop_front();
            exp_q.push_back('{cyc: t, word: m_cmd});
            m_active    = 1'b1;
            m_wait_from = t + 2;
            m_tmo_at    = t + 1 + TIMEOUT;
            if (force_tmo) done_at = -1;
            else if (next_lat > 0) begin
                done_at  = t + next_lat;
                next_lat = 0;
            end else if ($urandom_range(0, 7) == 0) done_at = -1;
            else done_at = t + 1 + int'($urandom_range(1, 40));
        end
        if (do_push) mq.push_back(cmd_in);
        m_busy = m_active || (t < m_free_at - 1) || (mq.size() > 0);
        m_rdy  = (mq.size() < DEPTH);
    endtask

    task automatic drive_next(bit vld, logic [15:0] w);
        int tn;
        tn      = cyc + 1;
        cmd_vld = vld;
        cmd_in  = w;
        done    = (tn == done_at) || (spur_en && $urandom_range(0, 31) == 0);
        data    = (fix_data && tn == done_at) ? 16'h1234 : 16'($urandom);
        rsp_ack = ($urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) model_step(cyc);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((m_busy || (RB && m_rsp_vld)) && k < 3000) begin
            drive_next(1'b0, 16'h0000);
            tick();
            k++;
        end
        check("drain_bound", 32'(k < 3000), 32'd1);
    endtask

    // Monitor: pops the expected issue on every wrt and compares the status outputs each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL wrt_missing at cycle %0d: no wrt, expected one at cycle %0d cmd %h",
                         cyc, exp_q[0].cyc, exp_q[0].word);
                void'(exp_q.pop_front());
            end
            if (wrt) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wrt_unexpected at cycle %0d: got wrt cmd %h, expected no wrt", cyc, cmd);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wrt_cycle", 32'(cyc), 32'(mon_e.cyc));
                    check("wrt_cmd", 32'(cmd), 32'(mon_e.word));
                end
            end
            check("cmd", 32'(cmd), 32'(m_cmd));
            check("busy", 32'(busy), 32'(m_busy));
            check("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
            check("err", 32'(err), 32'(m_err));
            check("rsp_vld", 32'(rsp_vld), 32'(m_rsp_vld));
            check("rsp", 32'(rsp), 32'(m_rsp));
        end
    end

    initial begin
        rst_n = 1'b0; cmd_in = 16'h0000; cmd_vld = 1'b0; done = 1'b0; data = 16'h0000; rsp_ack = 1'b0;
        chk_en = 1'b0; spur_en = 1'b0; force_tmo = 1'b0; fix_data = 1'b0; next_lat = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("reset_wrt", 32'(wrt), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd", 32'(cmd), 32'h0000);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single command answered 40 cycles after the push.
        next_lat = 39;
        fix_data = 1'b1;
        drive_next(1'b1, 16'hA5C3);
        tick();
        repeat (60) begin
            drive_next(1'b0, 16'h0000);
            tick();
        end
        fix_data = 1'b0;
        drain();

        // Bursts of 6 pushes against a 4-deep FIFO, exercising full, drops and pointer wrap.
        repeat (3) begin
            for (int i = 0; i < 6; i++) begin
                drive_next(1'b1, 16'($urandom));
                tick();
            end
            drain();
        end

        // Timeout on the first command, second command queued behind it.
        force_tmo = 1'b1;
        drive_next(1'b1, 16'h0BAD);
        tick();
        drive_next(1'b1, 16'h600D);
        tick();
        force_tmo = 1'b0;
        drain();

        // Random traffic with stray done pulses.
        spur_en = 1'b1;
        repeat (1500) begin
            drive_next($urandom_range(0, 3) == 0, 16'($urandom));
            tick();
        end
        spur_en = 1'b0;
        drain();

        // Reset while waiting for done with 3 words queued.
        force_tmo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_next(1'b1, 16'($urandom));
            tick();
        end
        drive_next(1'b0, 16'h0000);
        tick();
        check("pre_reset_queued", 32'(mq.size()), 32'd3);
        rst_n  = 1'b0;
        chk_en = 1'b0;
        #1;
        check("midrst_wrt", 32'(wrt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_rdy", 32'(cmd_rdy), 32'd1);
        check("midrst_cmd", 32'(cmd), 32'h0000);
        check("midrst_rsp", 32'(rsp), 32'h0000);
        check("midrst_rsp_vld", 32'(rsp_vld), 32'd0);
        model_reset();
        force_tmo = 1'b0;
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (30) begin
            drive_next(1'b0, 16'h0000);
            tick();
        end
        check("leftover_issues", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
